// File: rtl/stone_plotter.sv
// Pixel-write initiator: turns one board-cell draw command into the 25-slot
// raster of x/y/colour/plot writes for a 5x5 stone or cursor ring.
module stone_plotter #(
  parameter int BOARD_N  = 15,
  parameter int ORIGIN_X = 28,
  parameter int ORIGIN_Y = 8,
  parameter int PITCH    = 7
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic [2:0] colour_in,
  input  logic       mode,
  output logic       ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_r;
  logic [3:0] row_r;
  logic [3:0] col_r;
  logic [2:0] colour_r;
  logic       mode_r;
  logic [7:0] bx_r;
  logic [6:0] by_r;
  logic [2:0] dx_r;
  logic [2:0] dy_r;

  logic       cmd_ok_s;
  logic [7:0] bx_s;
  logic [6:0] by_s;
  logic [2:0] nx_s;
  logic [2:0] ny_s;
  logic       last_s;

  // Stone skips the four box corners; ring keeps only the outer border.
  function automatic logic mask_f(input logic m, input logic [2:0] dx, input logic [2:0] dy);
    logic edge_x;
    logic edge_y;
    edge_x = (dx == 3'd0) || (dx == 3'd4);
    edge_y = (dy == 3'd0) || (dy == 3'd4);
    if (m) begin
      return edge_x || edge_y;
    end else begin
      return !(edge_x && edge_y);
    end
  endfunction

  // Command validity check on the live inputs (only used while idle).
  always_comb begin
    cmd_ok_s = ({1'b0, row} < 5'(BOARD_N)) && ({1'b0, col} < 5'(BOARD_N));
  end

  // Box corner computed at 9 bits, then truncated to the adapter widths.
  always_comb begin
    bx_s = 8'(9'(ORIGIN_X) + 9'(col_r) * 9'(PITCH) - 9'd2);
    by_s = 7'(9'(ORIGIN_Y) + 9'(row_r) * 9'(PITCH) - 9'd2);
  end

  // Next raster position, dx fastest.
  always_comb begin
    last_s = (dx_r == 3'd4) && (dy_r == 3'd4);
    if (dx_r == 3'd4) begin
      nx_s = 3'd0;
      ny_s = dy_r + 3'd1;
    end else begin
      nx_s = dx_r + 3'd1;
      ny_s = dy_r;
    end
  end

  // Command FSM with registered pixel-port outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      row_r    <= 4'd0;
      col_r    <= 4'd0;
      colour_r <= 3'd0;
      mode_r   <= 1'b0;
      bx_r     <= 8'd0;
      by_r     <= 7'd0;
      dx_r     <= 3'd0;
      dy_r     <= 3'd0;
      ready    <= 1'b1;
      x        <= 8'd0;
      y        <= 7'd0;
      colour   <= 3'd0;
      plot     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            if (cmd_ok_s) begin
              row_r    <= row;
              col_r    <= col;
              colour_r <= colour_in;
              mode_r   <= mode;
              ready    <= 1'b0;
              state_r  <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          bx_r    <= bx_s;
          by_r    <= by_s;
          dx_r    <= 3'd0;
          dy_r    <= 3'd0;
          x       <= bx_s;
          y       <= by_s;
          colour  <= colour_r;
          plot    <= mask_f(mode_r, 3'd0, 3'd0);
          err     <= 1'b0;
          state_r <= SCAN;
        end
        SCAN: begin
          if (last_s) begin
            plot    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            dx_r <= nx_s;
            dy_r <= ny_s;
            x    <= bx_r + 8'(nx_s);
            y    <= by_r + 7'(ny_s);
            plot <= mask_f(mode_r, nx_s, ny_s);
          end
        end
        DONE: begin
          plot    <= 1'b0;
          done    <= 1'b0;
          ready   <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          plot    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
          ready   <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stone_plotter.sv
// Directed self-checking bench for stone_plotter: per-cycle raster checks
// against a small independent pixel model plus hand-computed landmarks.
module tb_stone_plotter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] row = 4'd0;
  logic [3:0] col = 4'd0;
  logic [2:0] colour_in = 3'd0;
  logic       mode = 1'b0;
  logic       ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  int plot_cnt, done_cnt, hole_hits;
  int first_x, first_y, last_x, last_y;
  logic [3:0] n_row, n_col;
  logic [2:0] n_colour;
  logic       n_mode;

  always #5 clk = ~clk;

  stone_plotter dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .start     (start),
    .row       (row),
    .col       (col),
    .colour_in (colour_in),
    .mode      (mode),
    .ready     (ready),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .done      (done),
    .err       (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ring: everything but the 3x3 interior. Stone: everything but the corners.
  function automatic bit model_plot(input bit m, input int dx, input int dy);
    bit corner;
    bit inner;
    corner = (dx == 0 || dx == 4) && (dy == 0 || dy == 4);
    inner  = (dx >= 1 && dx <= 3) && (dy >= 1 && dy <= 3);
    return m ? !inner : !corner;
  endfunction

  // Follows one accepted command cycle by cycle from T+1 to T+28.
  task automatic track(input int r, input int c, input int colr, input bit m,
                       input bit in_t1, input bit pokes, input bit chain);
    int bx;
    int by;
    int k;
    bit ep;
    bx = 28 + c * 7 - 2;
    by = 8 + r * 7 - 2;
    if (!in_t1) @(negedge clk);
    start = 1'b0;
    plot_cnt = 0; done_cnt = 0; hole_hits = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    for (int t = 1; t <= 28; t++) begin
      k  = t - 2;
      ep = (k >= 0 && k <= 24) ? model_plot(m, k % 5, k / 5) : 1'b0;
      check_eq("ready", ready, (t == 28));
      check_eq("plot", plot, ep);
      check_eq("done", done, (t == 27));
      check_eq("err", err, 0);
      if (k >= 0 && k <= 24) begin
        check_eq("x", x, bx + k % 5);
        check_eq("y", y, by + k / 5);
        check_eq("colour", colour, colr);
      end else if (t >= 27) begin
        check_eq("x_hold", x, bx + 4);
        check_eq("y_hold", y, by + 4);
      end
      if (plot) begin
        plot_cnt++;
        if (first_x < 0) begin
          first_x = x; first_y = y;
        end
        last_x = x; last_y = y;
        if (x == 8'd126 && y == 7'd106) hole_hits++;
      end
      if (done) done_cnt++;
      if (pokes && (t == 5 || t == 20)) begin
        start = 1'b1; row = 4'd2; col = 4'd9; colour_in = 3'b001; mode = ~mode;
      end else if (pokes && (t == 6 || t == 21)) begin
        start = 1'b0;
      end
      if (chain && t == 28) begin
        start = 1'b1; row = n_row; col = n_col; colour_in = n_colour; mode = n_mode;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_plot", plot, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_x", x, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_colour", colour, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Stone at the top-left intersection.
    row = 4'd0; col = 4'd0; colour_in = 3'b111; mode = 1'b0; start = 1'b1;
    track(0, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("stone_count", plot_cnt, 21);
    check_eq("stone_first_x", first_x, 27);
    check_eq("stone_first_y", first_y, 6);
    check_eq("stone_last_x", last_x, 29);
    check_eq("stone_last_y", last_y, 10);
    check_eq("stone_dones", done_cnt, 1);

    // Ring at the bottom-right intersection, with ignored starts mid-command.
    row = 4'd14; col = 4'd14; colour_in = 3'b100; mode = 1'b1; start = 1'b1;
    track(14, 14, 4, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("ring_count", plot_cnt, 16);
    check_eq("ring_hole", hole_hits, 0);
    check_eq("ring_first_x", first_x, 124);
    check_eq("ring_first_y", first_y, 104);
    check_eq("ring_last_x", last_x, 128);
    check_eq("ring_last_y", last_y, 108);
    check_eq("ring_dones", done_cnt, 1);

    // Invalid command on its own: err for exactly one cycle, nothing else.
    row = 4'd15; col = 4'd3; colour_in = 3'b010; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check_eq("inv_err", err, (i == 1));
      check_eq("inv_ready", ready, 1);
      check_eq("inv_plot", plot, 0);
      check_eq("inv_done", done, 0);
      @(negedge clk);
    end

    // Invalid col, then a valid start in the very next cycle.
    row = 4'd3; col = 4'd15; start = 1'b1;
    @(negedge clk);
    check_eq("inv2_err", err, 1);
    check_eq("inv2_ready", ready, 1);
    check_eq("inv2_plot", plot, 0);
    row = 4'd7; col = 4'd7; colour_in = 3'b010; mode = 1'b0; start = 1'b1;
    n_row = 4'd1; n_col = 4'd13; n_colour = 3'b101; n_mode = 1'b1;
    track(7, 7, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("mid_count", plot_cnt, 21);
    check_eq("mid_first_x", first_x, 76);
    check_eq("mid_first_y", first_y, 55);
    // Back-to-back ring accepted on the edge ending T+28.
    track(1, 13, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("b2b_count", plot_cnt, 16);
    check_eq("b2b_first_x", first_x, 117);
    check_eq("b2b_first_y", first_y, 13);
    check_eq("b2b_dones", done_cnt, 1);

    // Reset in the middle of a scan.
    row = 4'd5; col = 4'd5; colour_in = 3'b011; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre_rst_plot", plot, 1);
    resetn = 1'b0;
    #1;
    check_eq("mrst_ready", ready, 1);
    check_eq("mrst_plot", plot, 0);
    check_eq("mrst_done", done, 0);
    check_eq("mrst_err", err, 0);
    check_eq("mrst_x", x, 0);
    check_eq("mrst_y", y, 0);
    check_eq("mrst_colour", colour, 0);
    @(negedge clk);
    resetn = 1'b1;
    plot_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (plot) plot_cnt++;
      if (done) done_cnt++;
    end
    check_eq("mrst_no_plot", plot_cnt, 0);
    check_eq("mrst_no_done", done_cnt, 0);
    check_eq("mrst_ready_after", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
